// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the round-robin stream multiplexer.
// No logic; mode encoding and index-width helper only.
// No flow control at this level.
package stream_mux_pkg;

  typedef enum logic {
    MODE_SELECT = 1'b0,
    MODE_RR     = 1'b1
  } mux_mode_e;

  // Index width that stays at least one bit even for a single channel.
  function automatic int ch_w(input int n);
    if ($clog2(n) < 1) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotate-priority request search: first requester after ptr, wrapping mod N.
// Latency: combinational.
// Backpressure: none; callers gate the grant with their own load enable.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N = 4,
  localparam int CH_W = ch_w(N)
) (
  input  logic [N-1:0]    req,
  input  logic [CH_W-1:0] ptr,
  output logic [N-1:0]    gnt_onehot,
  output logic [CH_W-1:0] gnt_idx,
  output logic            any
);

  always_comb begin
    int idx;
    idx        = 0;
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    // Scan starts one past the last winner so that channel gets lowest priority.
    for (int i = 1; i <= N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!any && req[idx]) begin
        any             = 1'b1;
        gnt_idx         = CH_W'(idx);
        gnt_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel stream mux, SELECT or ROUND_ROBIN mode, with packet lock on in_last.
// Latency: 1 cycle input->output through a single output register.
// Backpressure: all in_ready low while out_valid && !out_ready; full rate when draining.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  localparam int CH_W = ch_w(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [CH_W-1:0]       sel,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH-1:0]       in_last,
  output logic [N_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [CH_W-1:0]       out_ch,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic              load_en;
  logic              xfer;
  logic              locked;
  logic [CH_W-1:0]   lock_ch;
  logic [CH_W-1:0]   rr_ptr;
  logic [N_CH-1:0]   gnt_oh;
  logic [CH_W-1:0]   gnt_idx;
  logic [N_CH-1:0]   arb_onehot;
  logic [CH_W-1:0]   arb_idx;
  logic              arb_any;
  logic [WIDTH-1:0]  mux_dat;
  logic              mux_last;
  mux_mode_e         cur_mode;

  assign cur_mode = mux_mode_e'(mode);
  assign load_en  = !out_valid || out_ready;

  rr_arbiter #(.N(N_CH)) u_arb (
    .req        (in_valid),
    .ptr        (rr_ptr),
    .gnt_onehot (arb_onehot),
    .gnt_idx    (arb_idx),
    .any        (arb_any)
  );

  // A held lock overrides both mode and sel until the packet's last beat.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    if (locked) begin
      gnt_idx = lock_ch;
      for (int k = 0; k < N_CH; k++)
        if (CH_W'(k) == lock_ch) gnt_oh[k] = 1'b1;
    end else if (cur_mode == MODE_RR) begin
      gnt_idx = arb_idx;
      gnt_oh  = arb_any ? arb_onehot : '0;
    end else begin
      gnt_idx = sel;
      for (int k = 0; k < N_CH; k++)
        if (CH_W'(k) == sel) gnt_oh[k] = 1'b1;
    end
  end

  assign in_ready = gnt_oh & in_valid & {N_CH{load_en && rst_n}};
  assign xfer     = |in_ready;

  // Only the granted channel's data can reach the register.
  always_comb begin
    mux_dat  = '0;
    mux_last = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (gnt_oh[k]) begin
        mux_dat  = in_data[k*WIDTH +: WIDTH];
        mux_last = in_last[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
      locked    <= 1'b0;
      lock_ch   <= '0;
      rr_ptr    <= CH_W'(N_CH - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= mux_dat;
      out_ch    <= gnt_idx;
      out_last  <= mux_last;
      locked    <= !mux_last;
      lock_ch   <= gnt_idx;
      if (mux_last && cur_mode == MODE_RR) rr_ptr <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr with an ordering scoreboard on accepted beats.
module tb_stream_mux_rr;
  import stream_mux_pkg::*;

  localparam int N_CH  = 4;
  localparam int WIDTH = 8;
  localparam int CH_W  = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  mode = 1'b0;
  logic [CH_W-1:0]       sel = '0;
  logic [N_CH*WIDTH-1:0] in_data = '0;
  logic [N_CH-1:0]       in_valid = '0;
  logic [N_CH-1:0]       in_last = '0;
  logic [N_CH-1:0]       in_ready;
  logic [WIDTH-1:0]      out_data;
  logic [CH_W-1:0]       out_ch;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  ch_dat [4];
  logic [10:0] sb_q [$];

  always #5 clk = ~clk;

  stream_mux_rr #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every accepted input beat must appear at the output exactly once, in order.
  always @(posedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) check("sb_spurious_beat", 32'(out_ch), 32'hFFFF);
        else check("sb_beat", 32'({out_ch, out_data, out_last}), 32'(sb_q.pop_front()));
      end
      for (int k = 0; k < N_CH; k++)
        if (in_valid[k] && in_ready[k])
          sb_q.push_back({2'(k), in_data[k*WIDTH +: WIDTH], in_last[k]});
    end
  end

  initial begin
    int exp_ch [4];
    int exp_lst [4];
    ch_dat = '{8'h3C, 8'h11, 8'hA5, 8'hD2};
    for (int k = 0; k < N_CH; k++) in_data[k*WIDTH +: WIDTH] = ch_dat[k];

    // Reset with traffic presented
    rst_n = 1'b0; in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1'b1; mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data",  32'(out_data), 0);
    check("rst_out_ch",    32'(out_ch), 0);
    check("rst_out_last",  32'(out_last), 0);
    check("rst_in_ready",  32'(in_ready), 0);

    // SELECT: selected channel not valid -> nothing
    @(negedge clk); rst_n = 1'b1; in_valid = 4'b1011; sel = 2'd2;
    #1 check("sel_invalid_rdy", 32'(in_ready), 0);
    @(posedge clk); #1 check("sel_invalid_ov", 32'(out_valid), 0);

    // SELECT: ch2 beat A5
    @(negedge clk); in_valid = 4'b1111;
    #1 check("sel_rdy", 32'(in_ready), 'h4);
    @(posedge clk); #1;
    check("sel_ov",   32'(out_valid), 1);
    check("sel_data", 32'(out_data), 'hA5);
    check("sel_ch",   32'(out_ch), 2);
    check("sel_last", 32'(out_last), 1);
    @(negedge clk); in_valid = 4'b0000;
    @(posedge clk); #1;
    check("drain_ov",   32'(out_valid), 0);
    check("drain_hold", 32'(out_data), 'hA5);

    // ROUND_ROBIN, all valid, single-beat packets
    @(negedge clk); mode = 1'b1; in_valid = 4'b1111; in_last = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      check("rr_ch",   32'(out_ch), i % 4);
      check("rr_data", 32'(out_data), 32'(ch_dat[i % 4]));
    end
    @(negedge clk); in_valid = 4'b0000;
    @(posedge clk);

    // Packet lock: ch1 3-beat packet while ch0/ch2 valid
    exp_ch  = '{1, 1, 1, 2};
    exp_lst = '{0, 0, 1, 1};
    for (int b = 0; b < 4; b++) begin
      @(negedge clk); in_valid = 4'b0111; in_last = (b >= 2) ? 4'b1111 : 4'b1101;
      @(posedge clk); #1;
      check("lock_ch",   32'(out_ch), exp_ch[b]);
      check("lock_last", 32'(out_last), exp_lst[b]);
    end
    @(negedge clk); in_valid = 4'b0000;
    @(posedge clk);

    // Backpressure: 5 stalled cycles then full rate
    @(negedge clk); in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1'b0;
    @(posedge clk); #1 check("bp_first_ch", 32'(out_ch), 3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_ch",   32'(out_ch), 3);
      check("bp_hold_data", 32'(out_data), 'hD2);
      check("bp_hold_ov",   32'(out_valid), 1);
      check("bp_in_ready",  32'(in_ready), 0);
    end
    @(negedge clk); out_ready = 1'b1;
    #1 check("bp_resume_rdy", 32'(in_ready), 'h1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 check("bp_resume_ch", 32'(out_ch), i);
    end
    @(negedge clk); in_valid = 4'b0000;
    @(posedge clk); #1 check("bp_drain_ov", 32'(out_valid), 0);

    // Mode switch while locked on ch0, including a mid-packet stall
    @(negedge clk); mode = 1'b1; in_valid = 4'b0001; in_last = 4'b0000;
    @(posedge clk); #1;
    check("ms_beat1_ch",   32'(out_ch), 0);
    check("ms_beat1_last", 32'(out_last), 0);
    @(negedge clk); mode = 1'b0; sel = 2'd3; in_valid = 4'b1001;
    @(posedge clk); #1 check("ms_beat2_ch", 32'(out_ch), 0);
    @(negedge clk); in_valid = 4'b1000;
    #1 check("ms_starve_rdy", 32'(in_ready), 0);
    @(posedge clk); #1 check("ms_starve_ov", 32'(out_valid), 0);
    @(negedge clk); in_valid = 4'b1001; in_last = 4'b1111;
    @(posedge clk); #1;
    check("ms_beat3_ch",   32'(out_ch), 0);
    check("ms_beat3_last", 32'(out_last), 1);
    @(posedge clk); #1 check("ms_sel3_ch", 32'(out_ch), 3);
    @(negedge clk); in_valid = 4'b0000;
    @(posedge clk);

    // Reset mid-packet: async clear, lock dropped
    @(negedge clk); mode = 1'b1; in_valid = 4'b0010; in_last = 4'b0000;
    @(posedge clk); #1 check("mid_pkt_ch", 32'(out_ch), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ov",   32'(out_valid), 0);
    check("async_rst_data", 32'(out_data), 0);
    check("async_rst_rdy",  32'(in_ready), 0);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1; in_valid = 4'b1111; in_last = 4'b1111;
    #1 check("post_rst_rdy", 32'(in_ready), 'h1);
    @(posedge clk); #1 check("post_rst_ch", 32'(out_ch), 0);
    @(negedge clk); in_valid = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check("final_ov",      32'(out_valid), 0);
    check("sb_leftover",   32'(sb_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
